// File: rtl/rgb_pwm_pkg.sv
// rtl/rgb_pwm_pkg.sv - shared widths, colour byte slices and fade step helper
package rgb_pwm_pkg;

  localparam int CHAN_W = 8;

  localparam int R_HI = 23;
  localparam int R_LO = 16;
  localparam int G_HI = 15;
  localparam int G_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  // Move d toward t by at most step; lands exactly on t when closer than step.
  function automatic logic [CHAN_W-1:0] sat_step(input logic [CHAN_W-1:0] d,
                                                 input logic [CHAN_W-1:0] t,
                                                 input logic [CHAN_W-1:0] step);
    logic [CHAN_W:0] diff;
    if (t > d) begin
      diff     = {1'b0, t} - {1'b0, d};
      sat_step = (diff > {1'b0, step}) ? d + step : t;
    end else begin
      diff     = {1'b0, d} - {1'b0, t};
      sat_step = (diff > {1'b0, step}) ? d - step : t;
    end
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// rtl/rgb_pwm_driver_if.sv - colour input and PWM output bundle of the RGB driver
interface rgb_pwm_driver_if
  import rgb_pwm_pkg::*;
;
  logic [3*CHAN_W-1:0] light;
  logic                enable;
  logic                fade_en;
  logic                pwm_r;
  logic                pwm_g;
  logic                pwm_b;
  logic [3*CHAN_W-1:0] duty;
  logic                period_done;

  modport master (
    output light, enable, fade_en,
    input  pwm_r, pwm_g, pwm_b, duty, period_done
  );

  modport slave (
    input  light, enable, fade_en,
    output pwm_r, pwm_g, pwm_b, duty, period_done
  );
endinterface

// File: rtl/rgb_pwm_channel.sv
// rtl/rgb_pwm_channel.sv - one colour channel: duty register with optional fade
// and registered PWM compare
module rgb_pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter int FADE_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              boundary,
  input  logic              fade_en,
  input  logic [CHAN_W-1:0] target,
  input  logic [CHAN_W-1:0] cnt,
  output logic [CHAN_W-1:0] duty,
  output logic              pwm
);

  localparam logic [CHAN_W-1:0] STEP = CHAN_W'(FADE_STEP);

  logic [CHAN_W-1:0] duty_q, duty_d;
  logic              pwm_q, pwm_d;

  always_comb begin
    duty_d = duty_q;
    if (boundary) begin
      duty_d = fade_en ? sat_step(duty_q, target, STEP) : target;
    end
    pwm_d = enable && (cnt < duty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign duty = duty_q;
  assign pwm  = pwm_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// rtl/rgb_pwm_driver.sv - three-channel LED PWM; colour adopted only at period
// boundaries so outputs never glitch mid-period
module rgb_pwm_driver
  import rgb_pwm_pkg::*;
#(
  parameter int PRESCALE  = 4,
  parameter int FADE_STEP = 1
) (
  input logic              clk,
  input logic              rst,
  rgb_pwm_driver_if.slave  bus
);

  localparam int              PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]   pre_q, pre_d;
  logic [CHAN_W-1:0] cnt_q, cnt_d;
  logic              pd_q, pd_d;
  logic              tick, boundary;
  logic [CHAN_W-1:0] duty_r, duty_g, duty_b;
  logic              pwm_r, pwm_g, pwm_b;

  // Dropping enable clears the timebase, which also suppresses a coincident boundary.
  always_comb begin
    tick     = bus.enable && (pre_q == PS_MAX);
    boundary = tick && (cnt_q == {CHAN_W{1'b1}});
    pre_d    = '0;
    cnt_d    = '0;
    if (bus.enable) begin
      pre_d = tick ? '0 : pre_q + PS_W'(1);
      cnt_d = tick ? cnt_q + CHAN_W'(1) : cnt_q;
    end
    pd_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
      pd_q  <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      pd_q  <= pd_d;
    end
  end

  rgb_pwm_channel #(.FADE_STEP(FADE_STEP)) u_chan_r (
    .clk(clk), .rst(rst), .enable(bus.enable), .boundary(boundary),
    .fade_en(bus.fade_en), .target(bus.light[R_HI:R_LO]), .cnt(cnt_q),
    .duty(duty_r), .pwm(pwm_r)
  );

  rgb_pwm_channel #(.FADE_STEP(FADE_STEP)) u_chan_g (
    .clk(clk), .rst(rst), .enable(bus.enable), .boundary(boundary),
    .fade_en(bus.fade_en), .target(bus.light[G_HI:G_LO]), .cnt(cnt_q),
    .duty(duty_g), .pwm(pwm_g)
  );

  rgb_pwm_channel #(.FADE_STEP(FADE_STEP)) u_chan_b (
    .clk(clk), .rst(rst), .enable(bus.enable), .boundary(boundary),
    .fade_en(bus.fade_en), .target(bus.light[B_HI:B_LO]), .cnt(cnt_q),
    .duty(duty_b), .pwm(pwm_b)
  );

  assign bus.duty        = {duty_r, duty_g, duty_b};
  assign bus.pwm_r       = pwm_r;
  assign bus.pwm_g       = pwm_g;
  assign bus.pwm_b       = pwm_b;
  assign bus.period_done = pd_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb/tb_rgb_pwm_driver.sv - scoreboard bench for rgb_pwm_driver
module tb_rgb_pwm_driver;

  typedef struct {
    logic [23:0] duty;
    bit          chk_hi;
    int          hr;
    int          hg;
    int          hb;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rgb_pwm_driver_if ifa ();
  rgb_pwm_driver_if ifb ();

  rgb_pwm_driver #(.PRESCALE(1), .FADE_STEP(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  rgb_pwm_driver #(.PRESCALE(3), .FADE_STEP(16)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   ha[3];
  int   hb[3];

  localparam logic [23:0] TA_LIGHT[8] = '{24'h000000, 24'h030000, 24'h030000, 24'h030000,
                                          24'h030000, 24'h010000, 24'h010000, 24'h010000};
  localparam bit          TA_FADE[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic [23:0] TA_DUTY[8]  = '{24'h000000, 24'h010000, 24'h020000, 24'h030000,
                                          24'h030000, 24'h020000, 24'h010000, 24'h010000};
  localparam int          TA_HR[8]    = '{16, 0, 1, 2, 3, 3, 2, 1};
  localparam int          TA_HGB[8]   = '{16, 0, 0, 0, 0, 0, 0, 0};

  localparam logic [7:0]  TB_G[13]  = '{8'd13, 8'd29, 8'd45, 8'd61, 8'd77, 8'd93, 8'd109,
                                        8'd125, 8'd141, 8'd157, 8'd173, 8'd189, 8'd200};
  localparam int          TB_HG[13] = '{24, 39, 87, 135, 183, 231, 279, 327, 375, 423,
                                        471, 519, 567};

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic score(input string tag, input exp_t e, input logic [23:0] duty,
                       input int h[3]);
    check({tag, "_duty"}, int'(duty), int'(e.duty));
    if (e.chk_hi) begin
      check({tag, "_hi_r"}, h[0], e.hr);
      check({tag, "_hi_g"}, h[1], e.hg);
      check({tag, "_hi_b"}, h[2], e.hb);
    end
  endtask

  task automatic push(input bit sel_b, input logic [23:0] duty, input bit chk,
                      input int r, input int g, input int b);
    exp_t e;
    e.duty   = duty;
    e.chk_hi = chk;
    e.hr     = r;
    e.hg     = g;
    e.hb     = b;
    if (sel_b) qb.push_back(e);
    else       qa.push_back(e);
  endtask

  task automatic wait_pd(input bit sel_b, input int max_cyc, output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if ((sel_b ? ifb.period_done : ifa.period_done) === 1'b1) break;
      if (cyc >= max_cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL pd_timeout: no period_done within %0d cycles (dut %0d)", max_cyc, sel_b);
        break;
      end
    end
  endtask

  // Each pulse closes a period: high-time counts cover the period that just ended.
  always @(negedge clk) begin
    if (rst) begin
      ha = '{0, 0, 0};
    end else begin
      ha[0] += int'(ifa.pwm_r);
      ha[1] += int'(ifa.pwm_g);
      ha[2] += int'(ifa.pwm_b);
      if (ifa.period_done === 1'b1) begin
        check("a_pd_expected", int'(qa.size() != 0), 1);
        if (qa.size() != 0) begin
          ea = qa.pop_front();
          score("a", ea, ifa.duty, ha);
        end
        ha = '{0, 0, 0};
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      hb = '{0, 0, 0};
    end else begin
      hb[0] += int'(ifb.pwm_r);
      hb[1] += int'(ifb.pwm_g);
      hb[2] += int'(ifb.pwm_b);
      if (ifb.period_done === 1'b1) begin
        check("b_pd_expected", int'(qb.size() != 0), 1);
        if (qb.size() != 0) begin
          eb = qb.pop_front();
          score("b", eb, ifb.duty, hb);
        end
        hb = '{0, 0, 0};
      end
    end
  end

  initial begin
    int cyc;
    rst         = 1'b1;
    ifa.light   = 24'hFFFFFF;
    ifa.enable  = 1'b1;
    ifa.fade_en = 1'b0;
    ifb.light   = 24'h000000;
    ifb.enable  = 1'b0;
    ifb.fade_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pwm_r", int'(ifa.pwm_r), 0);
    check("rst_pwm_g", int'(ifa.pwm_g), 0);
    check("rst_pwm_b", int'(ifa.pwm_b), 0);
    check("rst_duty", int'(ifa.duty), 0);
    check("rst_pd", int'(ifa.period_done), 0);

    ifa.light = 24'h80FF00;
    push(1'b0, 24'h80FF00, 1'b1, 0, 0, 0);
    rst = 1'b0;
    wait_pd(1'b0, 300, cyc);
    check("a_first_pd_latency", cyc, 256);

    push(1'b0, 24'h101010, 1'b1, 128, 255, 0);
    repeat (100) @(negedge clk);
    ifa.light = 24'h101010;
    check("a_duty_held_mid_period", int'(ifa.duty), 24'h80FF00);
    wait_pd(1'b0, 300, cyc);
    check("a_period_len", cyc, 156);

    for (int i = 0; i < 8; i++) begin
      ifa.light   = TA_LIGHT[i];
      ifa.fade_en = TA_FADE[i];
      push(1'b0, TA_DUTY[i], 1'b1, TA_HR[i], TA_HGB[i], TA_HGB[i]);
      wait_pd(1'b0, 300, cyc);
    end
    ifa.enable = 1'b0;

    ifb.light   = 24'h000800;
    ifb.fade_en = 1'b0;
    ifb.enable  = 1'b1;
    push(1'b1, 24'h000800, 1'b1, 0, 0, 0);
    wait_pd(1'b1, 800, cyc);
    check("b_first_pd_latency", cyc, 768);

    for (int i = 0; i < 13; i++) begin
      ifb.fade_en = 1'b1;
      ifb.light   = (i == 0) ? 24'h000D00 : 24'h00C800;
      push(1'b1, {8'h00, TB_G[i], 8'h00}, 1'b1, 0, TB_HG[i], 0);
      wait_pd(1'b1, 800, cyc);
    end

    repeat (150) @(negedge clk);
    check("b_pwm_g_running", int'(ifb.pwm_g), 1);
    ifb.enable = 1'b0;
    @(negedge clk);
    check("b_off_pwm_r", int'(ifb.pwm_r), 0);
    check("b_off_pwm_g", int'(ifb.pwm_g), 0);
    check("b_off_pwm_b", int'(ifb.pwm_b), 0);
    check("b_off_pd", int'(ifb.period_done), 0);
    repeat (1000) @(negedge clk);
    check("b_duty_retained", int'(ifb.duty), 24'h00C800);

    push(1'b1, 24'h00C800, 1'b0, 0, 0, 0);
    ifb.enable = 1'b1;
    wait_pd(1'b1, 900, cyc);
    check("b_reenable_latency", cyc, 768);

    repeat (4) @(negedge clk);
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
- Downstream stage of the lights selector. Consumes the 24-bit RGB colour it outputs (`light`).
- Drives three PWM pins (red, green, blue) for a physical RGB LED.
- New colours are adopted only at PWM period boundaries, so the outputs never glitch mid-period.
- Optional fade mode ramps each channel toward the new colour by a bounded step per period.

Parameters:
- PRESCALE, 4: clk cycles per PWM counter tick. Legal values are 1 and above; 1 means a tick every cycle.
- FADE_STEP, 1: maximum per-channel change of the duty value per PWM period when fading. Legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- light  input  24  target colour {R[23:16], G[15:8], B[7:0]}. Sampled only at a period boundary.
- enable  input  1  1 = PWM running; 0 = outputs forced low and counters cleared.
- fade_en  input  1  1 = ramp toward the target; 0 = load the target directly. Sampled at the boundary.
- pwm_r  output  1  red PWM.
- pwm_g  output  1  green PWM.
- pwm_b  output  1  blue PWM.
- duty  output  24  duty values currently applied, same packing as `light`.
- period_done  output  1  single-cycle pulse marking the start of a new period.

Behaviour:
- Reset (rst=1 at a clk edge):
  - prescaler, 8-bit counter cnt, duty, pwm_r/g/b and period_done all go to 0.
  - rst overrides enable; reset mid-period abandons the period with no boundary update.
- Prescaler:
  - Counts 0..PRESCALE-1 while enable=1.
  - tick = enable && (prescaler == PRESCALE-1).
  - cnt increments on tick and wraps 255 -> 0.
  - One period is 256*PRESCALE clk cycles.
- Boundary:
  - boundary = tick && (cnt == 255).
  - On that edge, cnt goes to 0 and duty is updated from `light` as below.
  - period_done is 1 for exactly the next cycle, the first cycle with cnt == 0 and the new duty.
- Duty update, per channel, with t = target byte and d = current duty:
  - fade_en=0: d <= t.
  - fade_en=1, t > d: d <= d + min(FADE_STEP, t-d).
  - fade_en=1, t < d: d <= d - min(FADE_STEP, d-t).
  - fade_en=1, t == d: d unchanged.
  - No overshoot and no wrap. Arithmetic is unsigned 8-bit with a 9-bit difference.
- Changes to `light` between boundaries are ignored. Only the value present on the boundary edge counts.
- PWM compare:
  - Registered: pwm_x <= enable && (cnt < d_x), evaluated every clk.
  - The output therefore lags cnt by one cycle.
  - d=0 gives constant low. d=255 gives high for 255 of 256 counts (255*PRESCALE cycles per period).
- enable deassert:
  - On the next edge, prescaler and cnt go to 0, pwm_x goes to 0 and period_done goes to 0.
  - duty holds its value.
- enable reassert: counting restarts from cnt=0, and the first boundary occurs 256*PRESCALE cycles later.
- Simultaneous boundary and enable falling edge: the boundary is not taken, because tick requires enable.

Decomposition:
- Package rgb_pwm_pkg holds:
  - CHAN_W = 8.
  - Byte slice constants R_HI/R_LO, G_HI/G_LO, B_HI/B_LO.
  - A saturating step function sat_step(d, t, step).
- Sub-module rgb_pwm_channel (inputs: clk, rst, enable, boundary, fade_en, target[7:0], cnt[7:0]; outputs: duty[7:0], pwm).
  - Instantiated three times.
  - The top level holds the prescaler, cnt, boundary and period_done logic.

Test Plan:
All scenarios use PRESCALE=1 unless stated.
1. Reset: hold rst for 2 cycles with light=24'hFFFFFF and enable=1 -> pwm_r/g/b=0, duty=0, period_done=0. The first period_done arrives 256 cycles after rst falls.
2. Direct load: fade_en=0, light=24'h80FF00. After the first period_done, duty=24'h80FF00, and the following period has pwm_r high for 128 cycles, pwm_g high for 255 cycles and pwm_b high for 0 cycles.
3. Mid-period change: set light=24'h10_10_10 at cnt=100 -> duty is unchanged until the next boundary, then equals 24'h101010.
4. Fade, FADE_STEP=1: duty R=0 and target R=3 -> R duty reads 1, 2, 3, 3 on successive period_done. Then set target to 1 -> 2, 1, 1.
5. Fade with no overshoot, FADE_STEP=16: duty G=8 and target G=13 -> G=13 after one boundary. Then target G=200 -> 29, 45, ..., 189, 200.
6. Enable and PRESCALE=3: deassert enable at cnt=50 -> all pwm low on the next edge and no period_done. Reassert -> the first period_done arrives 768 cycles later, and duty was retained throughout.
